// File: rtl/perf_report_pkg.sv
// Shared types and constants for the performance-counter report transmitter.
package perf_report_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    SEQ,
    PAY,
    CSUM
  } state_e;

  localparam int         PAY_BYTES      = 16;
  localparam int         WORDS          = 4;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/perf_report_tx_if.sv
// Byte-stream valid/ready link from the report transmitter to its sink.
interface perf_report_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/perf_byte_sel.sv
// Picks payload byte idx (0 = MSB of first word) out of the packed counter snapshot.
module perf_byte_sel
  import perf_report_pkg::*;
(
  input  logic [WORDS*32-1:0] snap,
  input  logic [3:0]          idx,
  output logic [7:0]          sel_byte
);

  logic [WORDS*32-1:0] shifted;

  always_comb begin
    shifted  = snap << {idx, 3'b000};
    sel_byte = shifted[WORDS*32-1 -: 8];
  end

endmodule

// File: rtl/perf_report_tx.sv
// Snapshots the performance counters on a trigger and sends them as a framed,
// XOR-checksummed byte stream. Define PERF_REPORT_SEQ_EN to add a frame sequence byte.
module perf_report_tx
  import perf_report_pkg::*;
#(
  parameter logic [7:0] HEADER       = DEFAULT_HEADER,
  parameter bit         AUTO_ON_DONE = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    done,
  input  logic                    report_req,
  input  logic [31:0]             num_inst,
  input  logic [31:0]             num_noops,
  input  logic [31:0]             num_mispredicts,
  input  logic [31:0]             result,
  perf_report_tx_if.master        tx,
  output logic                    busy,
  output logic                    overrun
);

  state_e              state;
  logic [3:0]          idx;
  logic [WORDS*32-1:0] snap_p0;
  logic [7:0]          csum;
  logic                pending;
  logic                done_q;
  logic [7:0]          byte_p1;
  logic                vld_p1;
`ifdef PERF_REPORT_SEQ_EN
  logic [7:0]          seq_p0;
`endif

  logic                trig;
  logic                accept;
  logic                last_accept;
  logic [3:0]          sel_idx;
  logic [7:0]          sel_byte;
  logic [WORDS*32-1:0] snap_in;

  function automatic logic [7:0] csum_acc(input logic [7:0] c, input logic [7:0] b);
    return c ^ b;
  endfunction

  assign trig        = report_req | ((AUTO_ON_DONE != 1'b0) & done & ~done_q);
  assign accept      = vld_p1 & tx.tx_ready;
  assign last_accept = (state == CSUM) & accept;
  assign snap_in     = {num_inst, num_noops, num_mispredicts, result};

  // Stage p0 -> p1: the byte following the one now on the bus
  assign sel_idx = (state == PAY) ? idx + 4'd1 : 4'd0;

  perf_byte_sel u_byte_sel (
    .snap     (snap_p0),
    .idx      (sel_idx),
    .sel_byte (sel_byte)
  );

  assign tx.tx_data  = byte_p1;
  assign tx.tx_valid = vld_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= 4'd0;
      snap_p0 <= '0;
      csum    <= 8'd0;
      pending <= 1'b0;
      overrun <= 1'b0;
      done_q  <= 1'b0;
      byte_p1 <= 8'd0;
      vld_p1  <= 1'b0;
      busy    <= 1'b0;
`ifdef PERF_REPORT_SEQ_EN
      seq_p0  <= 8'd0;
`endif
    end else begin
      done_q <= done;

      // A trigger landing on the final accept queues behind the pending one, if any
      if (state != IDLE) begin
        if (last_accept) begin
          pending <= pending & trig;
        end else if (trig) begin
          if (pending) overrun <= 1'b1;
          pending <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (trig) begin
            snap_p0 <= snap_in;
            csum    <= 8'd0;
            idx     <= 4'd0;
            state   <= HDR;
            byte_p1 <= HEADER;
            vld_p1  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        HDR: begin
          if (accept) begin
            idx <= 4'd0;
`ifdef PERF_REPORT_SEQ_EN
            state   <= SEQ;
            byte_p1 <= seq_p0;
`else
            state   <= PAY;
            byte_p1 <= sel_byte;
`endif
          end
        end
`ifdef PERF_REPORT_SEQ_EN
        SEQ: begin
          if (accept) begin
            csum    <= csum_acc(csum, byte_p1);
            idx     <= 4'd0;
            state   <= PAY;
            byte_p1 <= sel_byte;
          end
        end
`endif
        PAY: begin
          if (accept) begin
            csum <= csum_acc(csum, byte_p1);
            if (idx == 4'(PAY_BYTES - 1)) begin
              state   <= CSUM;
              byte_p1 <= csum_acc(csum, byte_p1);
            end else begin
              idx     <= idx + 4'd1;
              byte_p1 <= sel_byte;
            end
          end
        end
        CSUM: begin
          if (accept) begin
`ifdef PERF_REPORT_SEQ_EN
            seq_p0 <= seq_p0 + 8'd1;
`endif
            if (pending | trig) begin
              snap_p0 <= snap_in;
              csum    <= 8'd0;
              idx     <= 4'd0;
              state   <= HDR;
              byte_p1 <= HEADER;
            end else begin
              state   <= IDLE;
              byte_p1 <= 8'd0;
              vld_p1  <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          vld_p1 <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_report_tx.sv
// Scoreboard bench for perf_report_tx: stimulus pushes expected frame bytes, a monitor pops on each accept.
`timescale 1ns/1ps
module tb_perf_report_tx;

`ifdef PERF_REPORT_SEQ_EN
  localparam int FRAME_LEN = 19;
`else
  localparam int FRAME_LEN = 18;
`endif
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        done = 1'b0;
  logic        report_req = 1'b0;
  logic [31:0] num_inst = '0;
  logic [31:0] num_noops = '0;
  logic [31:0] num_mispredicts = '0;
  logic [31:0] result = '0;
  logic        busy;
  logic        overrun;

  perf_report_tx_if tx_if ();

  perf_report_tx #(.HEADER(HDR_BYTE), .AUTO_ON_DONE(1'b1)) dut (
    .clock           (clock),
    .reset           (reset),
    .done            (done),
    .report_req      (report_req),
    .num_inst        (num_inst),
    .num_noops       (num_noops),
    .num_mispredicts (num_mispredicts),
    .result          (result),
    .tx              (tx_if.master),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         acc_cnt = 0;
  int         cyc = 0;
  int         pos = 0;
  int         hdr_cyc[$];
  int         csum_cyc[$];
  logic [7:0] seq_seen[$];
  int         seq_m = 0;
  int         rdy_mode = 0;
  int         pcnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference frame built straight from the frame rules
  task automatic push_frame(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w[4];
    logic [7:0]  b;
    logic [7:0]  c;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    c = 8'd0;
    exp_q.push_back(HDR_BYTE);
`ifdef PERF_REPORT_SEQ_EN
    b = 8'(seq_m);
    exp_q.push_back(b);
    c = c ^ b;
    seq_m = (seq_m + 1) % 256;
`endif
    for (int i = 0; i < 4; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'((w[i] >> (8 * k)) & 32'hFF);
        exp_q.push_back(b);
        c = c ^ b;
      end
    end
    exp_q.push_back(c);
  endtask

  always @(posedge clock) cyc++;

  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0: tx_if.tx_ready = 1'b1;
        1: begin
          tx_if.tx_ready = ((pcnt % 4) == 0) || ((pcnt % 4) == 3);
          pcnt++;
        end
        default: tx_if.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      pos = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, tx_if.tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_if.tx_data}, {24'd0, prev_data});
      end
      if (tx_if.tx_valid) check("busy_with_valid", {31'd0, busy}, 32'd1);
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, tx_if.tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("frame_byte", {24'd0, tx_if.tx_data}, {24'd0, exp_q.pop_front()});
        end
        if (pos == 0) hdr_cyc.push_back(cyc);
        if (pos == FRAME_LEN - 1) csum_cyc.push_back(cyc);
`ifdef PERF_REPORT_SEQ_EN
        if (pos == 1) seq_seen.push_back(tx_if.tx_data);
`endif
        pos = (pos + 1) % FRAME_LEN;
        acc_cnt++;
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      tick();
      if (exp_q.size() == 0 && !busy) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_vals(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    num_inst = a; num_noops = b; num_mispredicts = c; result = d;
  endtask

  initial begin
    logic [7:0] lit[16];
    int         h;
    int         start;
    logic [31:0] r0, r1, r2, r3;

    // Reset state
    tick(); tick();
    check("rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_if.tx_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b1;
    tick();

    // Rising done, sink always ready: the documented literal frame
    set_vals(32'h0000_0010, 32'h3, 32'h1, 32'hDEAD_BEEF);
    lit = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h03,
            8'h00, 8'h00, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    exp_q.push_back(8'hA5);
`ifdef PERF_REPORT_SEQ_EN
    exp_q.push_back(8'h00);
    seq_m = 1;
`endif
    foreach (lit[i]) exp_q.push_back(lit[i]);
    exp_q.push_back(8'h30);
    done = 1'b1;
    tick();
    wait_idle(100);
    check("frame_cycles", 32'(csum_cyc[csum_cyc.size()-1] - hdr_cyc[hdr_cyc.size()-1]),
          32'(FRAME_LEN - 1));
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    done = 1'b0;
    tick();

    // Same values, sink ready pattern 1-0-0-1
    rdy_mode = 1;
    pcnt = 0;
    push_frame(32'h0000_0010, 32'h3, 32'h1, 32'hDEAD_BEEF);
    done = 1'b1;
    tick();
    wait_idle(200);
    done = 1'b0;
    rdy_mode = 0;
    tick(); tick();

    // Pending request, dropped request, back-to-back frame, mid-frame input change
    set_vals(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888);
    push_frame(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888);
    pulse_req();
    tick(); tick();
    set_vals(32'hCAFE_0001, 32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0);
    push_frame(32'hCAFE_0001, 32'h0BAD_F00D, 32'h1234_5678, 32'h9ABC_DEF0);
    pulse_req();
    tick();
    check("overrun_after_pending", {31'd0, overrun}, 32'd0);
    pulse_req();
    tick();
    check("overrun_set", {31'd0, overrun}, 32'd1);
    wait_idle(200);
    h = hdr_cyc.size();
    check("back_to_back", 32'(hdr_cyc[h-1]), 32'(csum_cyc[h-2] + 1));
    check("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Randomized values and sink backpressure; inputs scrambled mid-frame
    rdy_mode = 2;
    for (int n = 0; n < 6; n++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      set_vals(r0, r1, r2, r3);
      push_frame(r0, r1, r2, r3);
      pulse_req();
      tick(); tick();
      set_vals($urandom, $urandom, $urandom, $urandom);
      wait_idle(400);
    end
    rdy_mode = 0;
    tick();

    // Asynchronous reset while payload byte 7 is on the bus
    set_vals(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10);
    push_frame(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10);
    start = acc_cnt;
    pulse_req();
    for (int i = 0; i < 60 && acc_cnt < start + FRAME_LEN - 10; i++) tick();
    check("abort_reached", 32'(acc_cnt - start), 32'(FRAME_LEN - 10));
    #1;
    reset = 1'b0;
    exp_q.delete();
    seq_m = 0;
    #1;
    check("abort_valid", {31'd0, tx_if.tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_overrun", {31'd0, overrun}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    check("no_resume", {31'd0, busy}, 32'd0);
    push_frame(32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10);
    done = 1'b1;
    tick();
    wait_idle(100);
    for (int i = 0; i < 20; i++) tick();
    check("done_level_no_frame", {31'd0, busy}, 32'd0);
    done = 1'b0;
    tick();

`ifdef PERF_REPORT_SEQ_EN
    // Sequence numbering from reset through the 255 -> 0 wrap
    reset = 1'b0;
    tick();
    reset = 1'b1;
    seq_m = 0;
    seq_seen.delete();
    for (int n = 0; n < 257; n++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      set_vals(r0, r1, r2, r3);
      push_frame(r0, r1, r2, r3);
      pulse_req();
      wait_idle(60);
    end
    check("seq_count", 32'(seq_seen.size()), 32'd257);
    if (seq_seen.size() == 257) begin
      check("seq0", {24'd0, seq_seen[0]}, 32'h00);
      check("seq1", {24'd0, seq_seen[1]}, 32'h01);
      check("seq2", {24'd0, seq_seen[2]}, 32'h02);
      check("seq255", {24'd0, seq_seen[255]}, 32'hFF);
      check("seq_wrap", {24'd0, seq_seen[256]}, 32'h00);
    end
    check("seq_frame_len", 32'(csum_cyc[csum_cyc.size()-1] - hdr_cyc[hdr_cyc.size()-1]),
          32'd18);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
